// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared state encoding, RW/CS codes and helpers for the SPI transaction arbiter
package spi_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARB, SETUP, SHIFT, HOLD, DONE} state_e;
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;
  localparam logic [1:0] RW_RDWR = 2'b11;
  localparam logic [1:0] CS_IDLE = 2'b00;
  function automatic int max3(int a, int b, int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
  function automatic int unsigned wrap_inc(int unsigned i, int unsigned n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr_i
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);
  logic [IW:0] j;
  // Scan from the farthest offset down so the nearest hit is the last one written
  always_comb begin
    j = '0;
    idx_o = '0;
    valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr_i} + (IW + 1)'(k);
      j = (j >= (IW + 1)'(NUM_REQ)) ? j - (IW + 1)'(NUM_REQ) : j;
      if (req_i[j[IW-1:0]]) begin
        idx_o = j[IW-1:0];
        valid_o = 1'b1;
      end
    end
    gnt_o = valid_o ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin sharing of one SPI master, one 8-bit full-duplex transaction per grant
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int BYTE_CYCLES  = 9,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [2*NUM_REQ-1:0] req_cs_i,
  input  logic [2*NUM_REQ-1:0] req_mode_i,
  input  logic [2*NUM_REQ-1:0] req_rw_i,
  input  logic [8*NUM_REQ-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [7:0]           rdata_o,
  output logic                 busy_o,
  output logic                 spi_reset_o,
  output logic [1:0]           spi_cs_o,
  output logic [1:0]           spi_mode_o,
  output logic [1:0]           spi_rw_o,
  output logic [7:0]           spi_tx_data_o,
  input  logic [7:0]           spi_rx_data_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max3(SETUP_CYCLES, BYTE_CYCLES, HOLD_CYCLES)) + 1;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic err_q, err_d;
  logic [7:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [1:0] cs_q, cs_d, mode_q, mode_d, rw_q, rw_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0] arb_idx;
  logic arb_valid, cnt_z, on_bus;
  logic [1:0] win_cs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i(req_i),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .valid_o(arb_valid)
  );

  assign win_cs = req_cs_i[2*arb_idx +: 2];
  assign cnt_z  = cnt_q == '0;
  assign on_bus = state_q == SHIFT || state_q == HOLD;

  // Counter free-runs down by default; each state entry overrides with its reload value
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_z ? cnt_q : cnt_q - 1'b1;
    ptr_d = ptr_q;
    own_d = own_q;
    grant_d = grant_q;
    err_d = 1'b0;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    cs_d = cs_q;
    mode_d = mode_q;
    rw_d = rw_q;
    case (state_q)
      IDLE: state_d = |req_i ? ARB : IDLE;
      ARB: begin
        state_d = IDLE;
        if (arb_valid) begin
          own_d = arb_idx;
          cs_d = win_cs;
          mode_d = req_mode_i[2*arb_idx +: 2];
          rw_d = req_rw_i[2*arb_idx +: 2];
          wdata_d = req_wdata_i[8*arb_idx +: 8];
          if (win_cs == CS_IDLE) begin
            err_d = 1'b1;
            ptr_d = IW'(wrap_inc(32'(arb_idx), NUM_REQ));
          end else begin
            grant_d = arb_gnt;
            cnt_d = CW'(SETUP_CYCLES - 1);
            state_d = SETUP;
          end
        end
      end
      SETUP: if (cnt_z) begin
        state_d = SHIFT;
        cnt_d = CW'(BYTE_CYCLES - 1);
      end
      SHIFT: if (cnt_z) begin
        state_d = HOLD;
        cnt_d = CW'(HOLD_CYCLES - 1);
        rdata_d = rw_q[1] ? spi_rx_data_i : 8'h00;
      end
      HOLD: state_d = cnt_z ? DONE : HOLD;
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = IW'(wrap_inc(32'(own_q), NUM_REQ));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ptr_q <= '0;
      own_q <= '0;
      grant_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      cs_q <= CS_IDLE;
      mode_q <= '0;
      rw_q <= RW_NONE;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      grant_q <= grant_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      cs_q <= cs_d;
      mode_q <= mode_d;
      rw_q <= rw_d;
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = state_q == DONE;
  assign err_o         = err_q;
  assign rdata_o       = rdata_q;
  assign busy_o        = state_q != IDLE;
  assign spi_reset_o   = !on_bus;
  assign spi_cs_o      = on_bus ? cs_q : CS_IDLE;
  assign spi_mode_o    = mode_q;
  assign spi_rw_o      = rw_q;
  assign spi_tx_data_o = wdata_q;
endmodule
